// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, memory request handshake, 1-entry skid buffer and IF/ID register.
// Define IF_BRANCH_DELAY_SLOT_EN to keep the instruction fetched alongside a taken branch as a delay slot.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted
);

`ifdef IF_BRANCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        skid_valid, skid_valid_nx;
    logic [31:0] skid_instr, skid_instr_nx;
    logic [31:0] skid_pc4, skid_pc4_nx;
    logic        pend_valid, pend_valid_nx;
    logic        pend_kill, pend_kill_nx;
    logic [31:0] pend_target, pend_target_nx;
    logic [31:0] instr_q, instr_nx;
    logic [31:0] pc4_q, pc4_nx;
    logic        valid_q, valid_nx;

    logic        req_int;
    logic        accept;
    logic        outstanding;
    logic        keep_data;
    logic [31:0] target_al;
    logic [31:0] pc_plus4;

    assign target_al = branch_target & 32'hFFFF_FFFC;
    assign pc_plus4  = pc + 32'd4;

    always_comb begin
        req_int = 1'b0;
        unique case (state)
            RUN:     req_int = !skid_valid;
            DRAIN:   req_int = 1'b1;
            default: req_int = 1'b0;
        endcase
    end

    // Request is gated by rst so it drops the instant reset asserts, abandoning any open request.
    assign imem_req    = req_int && !rst;
    assign imem_addr   = pc;
    assign accept      = imem_req && imem_ready;
    assign outstanding = imem_req && !imem_ready;
    assign keep_data   = accept && !(pend_valid && pend_kill);

    // NOTE: every next-state variable takes its current value first, so no path can infer a latch.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        skid_valid_nx  = skid_valid;
        skid_instr_nx  = skid_instr;
        skid_pc4_nx    = skid_pc4;
        pend_valid_nx  = pend_valid;
        pend_kill_nx   = pend_kill;
        pend_target_nx = pend_target;
        instr_nx       = instr_q;
        pc4_nx         = pc4_q;
        valid_nx       = valid_q;

        // A redirect latched during a wait takes effect once the held request completes.
        if (accept) begin
            pc_nx         = pend_valid ? pend_target : pc_plus4;
            pend_valid_nx = 1'b0;
            pend_kill_nx  = 1'b0;
        end

        unique case (state)
            RUN: begin
                if (stall) begin
                    if (keep_data) begin
                        skid_valid_nx = 1'b1;
                        skid_instr_nx = imem_rdata;
                        skid_pc4_nx   = pc_plus4;
                    end
                end else if (halt) begin
                    valid_nx      = 1'b0;
                    skid_valid_nx = 1'b0;
                    state_nx      = outstanding ? DRAIN : HALTED;
                end else if (branch) begin
                    valid_nx      = 1'b0;
                    skid_valid_nx = 1'b0;
                    if (DELAY_SLOT && skid_valid) begin
                        instr_nx = skid_instr;
                        pc4_nx   = skid_pc4;
                        valid_nx = 1'b1;
                    end else if (DELAY_SLOT && keep_data) begin
                        instr_nx = imem_rdata;
                        pc4_nx   = pc_plus4;
                        valid_nx = 1'b1;
                    end
                    if (outstanding) begin
                        pend_valid_nx  = 1'b1;
                        pend_kill_nx   = !DELAY_SLOT;
                        pend_target_nx = target_al;
                    end else begin
                        pc_nx = target_al;
                    end
                end else if (skid_valid) begin
                    instr_nx      = skid_instr;
                    pc4_nx        = skid_pc4;
                    valid_nx      = 1'b1;
                    skid_valid_nx = 1'b0;
                end else if (keep_data) begin
                    instr_nx = imem_rdata;
                    pc4_nx   = pc_plus4;
                    valid_nx = 1'b1;
                end else begin
                    valid_nx = 1'b0;
                end
            end
            DRAIN: begin
                valid_nx      = 1'b0;
                skid_valid_nx = 1'b0;
                if (accept) state_nx = HALTED;
            end
            default: begin
                valid_nx      = 1'b0;
                skid_valid_nx = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc4    <= '0;
            pend_valid  <= 1'b0;
            pend_kill   <= 1'b0;
            pend_target <= '0;
            instr_q     <= '0;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            skid_valid  <= skid_valid_nx;
            skid_instr  <= skid_instr_nx;
            skid_pc4    <= skid_pc4_nx;
            pend_valid  <= pend_valid_nx;
            pend_kill   <= pend_kill_nx;
            pend_target <= pend_target_nx;
            instr_q     <= instr_nx;
            pc4_q       <= pc4_nx;
            valid_q     <= valid_nx;
        end
    end

    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign halted      = (state == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; memory returns its own address as the instruction word.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] branch_target;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch        (branch),
        .branch_target (branch_target),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; branch = 1'b0; halt = 1'b0;
        branch_target = 32'h0; imem_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_release_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_release_addr: got %h want 00000000", imem_addr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_release_valid: got %b want 0", if_id_valid); end
        tick(); tick();
        rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_async_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_async_pc: got %h want 00000000", imem_addr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %b want 0", if_id_valid); end
        total++; if (if_id_instr !== 32'h0) begin bad++; $display("FAIL rst_async_instr: got %h want 00000000", if_id_instr); end
        total++; if (if_id_pc4 !== 32'h0) begin bad++; $display("FAIL rst_async_pc4: got %h want 00000000", if_id_pc4); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_async_halted: got %b want 0", halted); end
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_rerelease_req: got %b want 1", imem_req); end
    endtask

    task automatic test_reset_abandon();
        do_reset();
        imem_ready = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        imem_ready = 1'b1;
        tick();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL abandon_valid: got %b want 0", if_id_valid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL abandon_req: got %b want 0", imem_req); end
        rst = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL abandon_addr: got %h want 00000000", imem_addr); end
        tick();
        total++; if (if_id_pc4 !== 32'h4 || if_id_valid !== 1'b1) begin bad++; $display("FAIL abandon_refetch: got pc4=%h v=%b want 00000004 v=1", if_id_pc4, if_id_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc4;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc4 = 32'(4 * i);
            total++;
            if (if_id_pc4 !== exp_pc4 || if_id_valid !== 1'b1 || if_id_instr !== exp_pc4 - 32'd4) begin
                bad++;
                $display("FAIL stream_%0d: got pc4=%h instr=%h v=%b want pc4=%h instr=%h v=1",
                         i, if_id_pc4, if_id_instr, if_id_valid, exp_pc4, exp_pc4 - 32'd4);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        tick(); tick();
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL br_pre_addr: got %h want 00000008", imem_addr); end
        branch = 1'b1; branch_target = 32'h100;
        tick();
        branch = 1'b0;
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL br_redirect_addr: got %h want 00000100", imem_addr); end
`ifdef IF_BRANCH_DELAY_SLOT_EN
        total++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'hC) begin bad++; $display("FAIL br_delay_slot: got pc4=%h v=%b want 0000000c v=1", if_id_pc4, if_id_valid); end
`else
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL br_squash: got v=%b want 0", if_id_valid); end
`endif
        tick();
        total++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h104) begin bad++; $display("FAIL br_target: got pc4=%h v=%b want 00000104 v=1", if_id_pc4, if_id_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        stall = 1'b1; branch = 1'b1; branch_target = 32'h200;
        tick();
        branch = 1'b0; halt = 1'b1;
        total++; if (if_id_pc4 !== 32'h8 || if_id_instr !== 32'h4) begin bad++; $display("FAIL stall_hold1: got pc4=%h instr=%h want 00000008 00000004", if_id_pc4, if_id_instr); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_skid_full_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL stall_branch_ignored: got %h want 0000000c", imem_addr); end
        tick();
        halt = 1'b0;
        total++; if (if_id_pc4 !== 32'h8 || imem_req !== 1'b0) begin bad++; $display("FAIL stall_hold2: got pc4=%h req=%b want 00000008 0", if_id_pc4, imem_req); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL stall_halt_ignored: got %b want 0", halted); end
        stall = 1'b0;
        tick();
        total++; if (if_id_pc4 !== 32'hC || if_id_instr !== 32'h8 || if_id_valid !== 1'b1) begin bad++; $display("FAIL stall_skid_drain: got pc4=%h instr=%h v=%b want 0000000c 00000008 1", if_id_pc4, if_id_instr, if_id_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin bad++; $display("FAIL stall_resume_req: got req=%b addr=%h want 1 0000000c", imem_req, imem_addr); end
        tick();
        total++; if (if_id_pc4 !== 32'h10 || if_id_valid !== 1'b1) begin bad++; $display("FAIL stall_resume_fetch: got pc4=%h v=%b want 00000010 1", if_id_pc4, if_id_valid); end
    endtask

    task automatic test_wait_branch();
        do_reset();
        tick();
        imem_ready = 1'b0; branch = 1'b1; branch_target = 32'h40;
        #1;
        total++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin bad++; $display("FAIL wait_start: got addr=%h req=%b want 00000004 1", imem_addr, imem_req); end
        tick();
        branch = 1'b0;
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL wait_addr_stable1: got %h want 00000004", imem_addr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL wait_bubble: got %b want 0", if_id_valid); end
        tick();
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL wait_addr_stable2: got %h want 00000004", imem_addr); end
        tick();
        imem_ready = 1'b1;
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL wait_addr_stable3: got %h want 00000004", imem_addr); end
        tick();
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL wait_redirect: got %h want 00000040", imem_addr); end
`ifdef IF_BRANCH_DELAY_SLOT_EN
        total++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h8) begin bad++; $display("FAIL wait_delay_slot: got pc4=%h v=%b want 00000008 1", if_id_pc4, if_id_valid); end
`else
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL wait_data_dropped: got v=%b want 0", if_id_valid); end
`endif
        tick();
        total++; if (if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1) begin bad++; $display("FAIL wait_target_fetch: got pc4=%h v=%b want 00000044 1", if_id_pc4, if_id_valid); end
    endtask

    task automatic test_halt_drain();
        do_reset();
        tick();
        imem_ready = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0;
        total++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL drain_enter: got halted=%b req=%b addr=%h want 0 1 00000004", halted, imem_req, imem_addr); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", if_id_valid); end
        tick();
        total++; if (halted !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL drain_wait: got halted=%b req=%b want 0 1", halted, imem_req); end
        imem_ready = 1'b1;
        tick();
        total++; if (halted !== 1'b1 || imem_req !== 1'b0 || if_id_valid !== 1'b0) begin bad++; $display("FAIL drain_done: got halted=%b req=%b v=%b want 1 0 0", halted, imem_req, if_id_valid); end
        branch = 1'b1; branch_target = 32'h80;
        repeat (5) tick();
        branch = 1'b0;
        total++; if (halted !== 1'b1 || imem_req !== 1'b0 || if_id_valid !== 1'b0) begin bad++; $display("FAIL halted_sticky: got halted=%b req=%b v=%b want 1 0 0", halted, imem_req, if_id_valid); end
        do_reset();
        total++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL halt_rst_exit: got halted=%b req=%b addr=%h want 0 1 00000000", halted, imem_req, imem_addr); end
    endtask

    task automatic test_halt_direct();
        do_reset();
        tick();
        halt = 1'b1; branch = 1'b1; branch_target = 32'h80;
        tick();
        halt = 1'b0; branch = 1'b0;
        total++; if (halted !== 1'b1 || imem_req !== 1'b0 || if_id_valid !== 1'b0) begin bad++; $display("FAIL halt_with_branch: got halted=%b req=%b v=%b want 1 0 0", halted, imem_req, if_id_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        branch = 1'b1; branch_target = 32'hFFFF_FFFE;
        tick();
        branch = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_align: got %h want fffffffc", imem_addr); end
        tick();
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 00000000", imem_addr); end
        total++; if (if_id_pc4 !== 32'h0 || if_id_instr !== 32'hFFFF_FFFC || if_id_valid !== 1'b1) begin bad++; $display("FAIL wrap_pc4: got pc4=%h instr=%h v=%b want 00000000 fffffffc 1", if_id_pc4, if_id_instr, if_id_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_abandon();
        test_stream();
        test_branch();
        test_stall();
        test_wait_branch();
        test_halt_drain();
        test_halt_direct();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
